// File: rtl/piso_serializer.sv
// Parallel-in/serial-out shifter with valid/ready load, shift_en-qualified bit rate,
// selectable bit order and gap-free back-to-back streaming.
module piso_serializer #(
    parameter int unsigned WIDTH      = 8,
    parameter bit          MSB_FIRST  = 1'b1,
    parameter bit          IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] data_in,
    input  logic             shift_en,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             busy,
    output logic             done
);

    localparam int unsigned   CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q,   cnt_d;
    logic             done_q,  done_d;
    logic             accept;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        accept  = load_valid && load_ready;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    shreg_d = data_in;
                    cnt_d   = CNT_LAST;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (shift_en) begin
                    if (cnt_q != '0) begin
                        if (MSB_FIRST) begin
                            shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                        end else begin
                            shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
                        end
                        cnt_d = cnt_q - CW'(1);
                    end else begin
                        // Last bit consumed: a word accepted on this same edge streams on with no gap.
                        done_d = 1'b1;
                        if (accept) begin
                            shreg_d = data_in;
                            cnt_d   = CNT_LAST;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        load_ready   = (state_q == IDLE) ||
                       ((state_q == SHIFT) && (cnt_q == '0) && shift_en);
        serial_valid = (state_q == SHIFT);
        busy         = (state_q == SHIFT);
        done         = done_q;
        if (state_q == SHIFT) begin
            serial_out = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
        end else begin
            serial_out = IDLE_LEVEL;
        end
    end

endmodule
